hamming_decoder: RTL and testbench

- Pipelined Hamming(7,4) decoder/corrector peripheral; receives the 32-bit word produced by the team's Hamming encoder peripheral:
  - two 7-bit codeword lanes, lane 1 in bits [13:7] and lane 0 in bits [6:0];
  - bits [31:14] are zero-padding.
- For each lane it computes the syndrome, corrects any single-bit error and returns the 4-bit data nibble.
- It keeps a saturating count of corrected lanes for CPU readout.
- It sits between the bus-facing register file and the ECC datapath; a valid/ready handshake on both sides absorbs back-pressure.

---
 rtl/hamming_pkg.sv | 63 ++++++
 rtl/hamming_decoder_if.sv | 26 ++
 rtl/hamming_lane_dec.sv | 24 ++
 rtl/hamming_decoder.sv | 104 ++++++++++
 tb/tb_hamming_decoder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Hamming(7,4) constants and lane-level helpers shared by the encoder and decoder.
// Lane bit map, MSB first: {c0,c1,c2,c3,c4,c5,c6}; data nibble is {c6,c5,c4,c3}.
package hamming_pkg;

  localparam int LANE_W    = 7;
  localparam int NIB_W     = 4;
  localparam int NUM_LANES = 2;
  localparam int SYN_W     = 3;
  localparam int CODE_W    = 32;

  // Parity equations, written in terms of the c-numbering rather than bit positions.
  function automatic logic par_c0(input logic c3, input logic c4, input logic c5);
    return c5 ^ c4 ^ c3;
  endfunction

  function automatic logic par_c1(input logic c4, input logic c5, input logic c6);
    return c6 ^ c5 ^ c4;
  endfunction

  function automatic logic par_c2(input logic c3, input logic c4, input logic c6);
    return c6 ^ c4 ^ c3;
  endfunction

  // c-number k lives at bit position (LANE_W-1-k).
  function automatic logic [LANE_W-1:0] encode(input logic [NIB_W-1:0] nib);
    logic c3, c4, c5, c6;
    c3 = nib[0];
    c4 = nib[1];
    c5 = nib[2];
    c6 = nib[3];
    return {par_c0(c3, c4, c5), par_c1(c4, c5, c6), par_c2(c3, c4, c6), c3, c4, c5, c6};
  endfunction

  // Returns {s2,s1,s0}.
  function automatic logic [SYN_W-1:0] calc_syn(input logic [LANE_W-1:0] cw);
    logic s0, s1, s2;
    s0 = cw[6] ^ par_c0(cw[3], cw[2], cw[1]);
    s1 = cw[5] ^ par_c1(cw[2], cw[1], cw[0]);
    s2 = cw[4] ^ par_c2(cw[3], cw[2], cw[0]);
    return {s2, s1, s0};
  endfunction

  // Bit position to flip for a non-zero syndrome; 000 is never used for a flip.
  function automatic logic [2:0] syn2idx(input logic [SYN_W-1:0] syn);
    logic [2:0] idx;
    case (syn)
      3'b001:  idx = 3'd6;
      3'b010:  idx = 3'd5;
      3'b100:  idx = 3'd4;
      3'b101:  idx = 3'd3;
      3'b111:  idx = 3'd2;
      3'b011:  idx = 3'd1;
      3'b110:  idx = 3'd0;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [NIB_W-1:0] get_nibble(input logic [LANE_W-1:0] cw);
    return {cw[0], cw[1], cw[2], cw[3]};
  endfunction

endpackage

// File: rtl/hamming_decoder_if.sv
// Stream interface of the Hamming decoder: codeword in, corrected result out.
interface hamming_decoder_if;
  import hamming_pkg::*;

  // Both sides: a transfer happens on a rising edge where valid & ready are both 1;
  // a source holding valid keeps its payload stable until that edge.
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [CODE_W-1:0]             code_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [NUM_LANES*NIB_W-1:0]    data_o;
  logic [NUM_LANES*SYN_W-1:0]    syndrome_o;
  logic [NUM_LANES-1:0]          err_o;

  modport slave (
    input  in_valid_i, code_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, syndrome_o, err_o
  );

  modport master (
    output in_valid_i, code_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, syndrome_o, err_o
  );

endinterface

// File: rtl/hamming_lane_dec.sv
// Correction half of one Hamming(7,4) lane: flips the bit named by a precomputed
// syndrome and extracts the data nibble.
module hamming_lane_dec
  import hamming_pkg::*;
(
  input  logic [LANE_W-1:0] code,
  input  logic [SYN_W-1:0]  syn,
  output logic [NIB_W-1:0]  nibble,
  output logic              err
);

  logic [LANE_W-1:0] fixed;

  // Double errors land here too and get miscorrected; that is the defined behaviour.
  always_comb begin
    fixed = code;
    err   = (syn != '0);
    if (err) begin
      fixed[syn2idx(syn)] = ~code[syn2idx(syn)];
    end
    nibble = get_nibble(fixed);
  end

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage Hamming(7,4) decoder for a pair of lanes with a saturating count of
// corrected lanes. Stage 1 holds codewords and syndromes, stage 2 the corrected result.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  hamming_decoder_if.slave      bus,
  input  logic                  clr_cnt_i,
  output logic [CNT_W-1:0]      corr_cnt_o
);

  localparam int PAIR_W = NUM_LANES * LANE_W;
  localparam int DATA_W = NUM_LANES * NIB_W;
  localparam int SYNS_W = NUM_LANES * SYN_W;

  logic              v1, v2;
  logic              adv2, in_ready, accept, fire;
  logic [PAIR_W-1:0] code1_q;
  logic [SYNS_W-1:0] syn1_q;
  logic [SYNS_W-1:0] syn_in;
  logic [DATA_W-1:0] nib_c;
  logic [NUM_LANES-1:0] err_c;
  logic [DATA_W-1:0] data2_q;
  logic [SYNS_W-1:0] syn2_q;
  logic [NUM_LANES-1:0] err2_q;
  logic              unused_pad;

  assign adv2     = !v2 || bus.out_ready_i;
  assign in_ready = !v1 || adv2;
  assign accept   = bus.in_valid_i && in_ready;
  assign fire     = v2 && bus.out_ready_i;

  assign unused_pad = ^bus.code_i[CODE_W-1:PAIR_W];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign syn_in[l*SYN_W +: SYN_W] = calc_syn(bus.code_i[l*LANE_W +: LANE_W]);

    hamming_lane_dec u_lane_dec (
      .code   (code1_q[l*LANE_W +: LANE_W]),
      .syn    (syn1_q[l*SYN_W +: SYN_W]),
      .nibble (nib_c[l*NIB_W +: NIB_W]),
      .err    (err_c[l])
    );
  end

  // Stage 2 is updated before stage 1 drains into it, so a word can enter
  // and another leave on the same edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      code1_q <= '0;
      syn1_q  <= '0;
      data2_q <= '0;
      syn2_q  <= '0;
      err2_q  <= '0;
    end else begin
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          data2_q <= nib_c;
          syn2_q  <= syn1_q;
          err2_q  <= err_c;
        end
      end
      if (in_ready) begin
        v1 <= bus.in_valid_i;
        if (accept) begin
          code1_q <= bus.code_i[PAIR_W-1:0];
          syn1_q  <= syn_in;
        end
      end
    end
  end

  logic [1:0]       err_pop;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_q;

  assign err_pop = {1'b0, err2_q[1]} + {1'b0, err2_q[0]};
  assign cnt_sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, err_pop};

  // The extra sum bit catches a +2 that jumps over all-ones.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_cnt_i) begin
      cnt_q <= '0;
    end else if (fire) begin
      cnt_q <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = v2;
  assign bus.data_o      = data2_q;
  assign bus.syndrome_o  = syn2_q;
  assign bus.err_o       = err2_q;
  assign corr_cnt_o      = cnt_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: hand-computed codewords, an output monitor
// with an expected queue, and explicit latency, back-pressure, counter and reset checks.
module tb_hamming_decoder;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic [CNT_W-1:0] cnt;

  hamming_decoder_if bus();

  hamming_decoder #(.CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .bus        (bus.slave),
    .clr_cnt_i  (clr),
    .corr_cnt_o (cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Entry: {syndrome[5:0], err[1:0], data[7:0]}
  logic [15:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always begin
    logic [15:0] e;
    @(negedge clk);
    #1;
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", {24'd0, bus.data_o}, {24'd0, e[7:0]});
        check("out_err", {30'd0, bus.err_o}, {30'd0, e[9:8]});
        check("out_syn", {26'd0, bus.syndrome_o}, {26'd0, e[15:10]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left on a falling edge.
  task automatic send(input logic [31:0] code, input logic [15:0] exp, input bit push_exp);
    int n = 0;
    bus.in_valid_i = 1'b1;
    bus.code_i     = code;
    #1;
    while (!bus.in_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd0, 32'd1);
    if (push_exp) exp_q.push_back(exp);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!bus.out_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("wait_valid_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  // Both lanes = 0x1D (nibble 0xB); syndromes by flipped bit position 0..6.
  localparam logic [31:0] CLEAN = 32'h0000_0E9D;
  logic [2:0]  syn_by_pos [7];
  logic [31:0] bp_words   [4];
  logic [7:0]  bp_data    [4];

  initial begin
    int n_acc;
    int idx;
    bit acc;
    logic [31:0] code;
    logic [15:0] e;

    syn_by_pos = '{3'b110, 3'b011, 3'b111, 3'b101, 3'b100, 3'b010, 3'b001};
    // Nibbles 1..4 in both lanes: lane codewords 0x58, 0x74, 0x2C, 0x62.
    bp_words   = '{32'h0000_2C58, 32'h0000_3A74, 32'h0000_162C, 32'h0000_3162};
    bp_data    = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst_n           = 1'b0;
    clr             = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.code_i      = '0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check("rst_data", {24'd0, bus.data_o}, 32'd0);
    check("rst_syn", {26'd0, bus.syndrome_o}, 32'd0);
    check("rst_err", {30'd0, bus.err_o}, 32'd0);
    check("rst_cnt", {28'd0, cnt}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean word and two-cycle latency.
    send(CLEAN, {6'h00, 2'b00, 8'hBB}, 1'b1);
    check("lat_not_yet", {31'd0, bus.out_valid_o}, 32'd0);
    @(negedge clk);
    check("lat_valid", {31'd0, bus.out_valid_o}, 32'd1);
    check("clean_data", {24'd0, bus.data_o}, 32'hBB);
    check("clean_err", {30'd0, bus.err_o}, 32'd0);
    drain();
    check("clean_cnt", {28'd0, cnt}, 32'd0);

    // Single error in lane 0, bit 2.
    send(32'h0000_0E99, {6'h07, 2'b01, 8'hBB}, 1'b1);
    drain();
    check("single_cnt", {28'd0, cnt}, 32'd1);

    // All 14 single-bit flips.
    for (int b = 0; b < 14; b++) begin
      code = CLEAN ^ (32'd1 << b);
      if (b < 7) e = {3'b000, syn_by_pos[b], 2'b01, 8'hBB};
      else       e = {syn_by_pos[b-7], 3'b000, 2'b10, 8'hBB};
      send(code, e, 1'b1);
    end
    drain();
    check("flips_cnt_sat", {28'd0, cnt}, 32'd15);

    // Pad bits only.
    send(32'hFFFF_C000, {6'h00, 2'b00, 8'h00}, 1'b1);
    drain();
    check("pad_cnt", {28'd0, cnt}, 32'd15);

    // Back-pressure: stall the output for 6 cycles with input held valid.
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    idx   = 0;
    n_acc = 0;
    bus.code_i = bp_words[0];
    for (int c = 0; c < 6; c++) begin
      #1;
      acc = bus.in_ready_o;
      if (acc) begin
        exp_q.push_back({6'h00, 2'b00, bp_data[idx]});
        n_acc++;
      end
      @(negedge clk);
      if (acc) begin
        idx++;
        bus.code_i = bp_words[idx];
      end
    end
    check("bp_accepted", n_acc, 32'd2);
    check("bp_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
    check("bp_hold_valid", {31'd0, bus.out_valid_o}, 32'd1);
    check("bp_hold_data", {24'd0, bus.data_o}, 32'h11);

    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("bp_no_gap", {31'd0, bus.out_valid_o}, 32'd1);
      acc = bus.in_valid_i && bus.in_ready_o;
      if (acc) exp_q.push_back({6'h00, 2'b00, bp_data[idx]});
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 4) bus.code_i = bp_words[idx];
        else         bus.in_valid_i = 1'b0;
      end
    end
    check("bp_all_sent", idx, 32'd4);
    drain();

    // Counter saturation with +2 per word (lane bit 2 flipped in both lanes).
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_cnt", {28'd0, cnt}, 32'd0);
    for (int w = 0; w < 10; w++) begin
      send(32'h0000_0C99, {6'h3F, 2'b11, 8'hBB}, 1'b1);
      drain();
      check("sat_cnt", {28'd0, cnt}, (2 * (w + 1) > 15) ? 32'd15 : 32'(2 * (w + 1)));
    end

    // Clear coinciding with an err = 11 handshake.
    bus.out_ready_i = 1'b0;
    send(32'h0000_0C99, {6'h3F, 2'b11, 8'hBB}, 1'b1);
    wait_out_valid();
    bus.out_ready_i = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_prio_cnt", {28'd0, cnt}, 32'd0);
    drain();

    // Reset with two words in flight.
    send(32'h0000_0E99, {6'h07, 2'b01, 8'hBB}, 1'b1);
    drain();
    check("pre_rst_cnt", {28'd0, cnt}, 32'd1);
    bus.out_ready_i = 1'b0;
    send(32'h0000_0C99, 16'h0, 1'b0);
    send(32'h0000_0E99, 16'h0, 1'b0);
    check("full_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check("midrst_cnt", {28'd0, cnt}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_idle", {31'd0, bus.out_valid_o}, 32'd0);
    end
    check("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
